// File: rtl/vga_pkg.sv
// Shared VGA sink definitions: sink FSM states, pixel width, and the 1280x1024@60
// timing constants also used by the timing generator.
package vga_pkg;

    localparam int unsigned RGB_W = 12;

    localparam int unsigned H_ACTIVE = 1280;
    localparam int unsigned H_FRONT  = 48;
    localparam int unsigned H_SYNC   = 112;
    localparam int unsigned H_BACK   = 248;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_ACTIVE = 1024;
    localparam int unsigned V_FRONT  = 1;
    localparam int unsigned V_SYNC   = 3;
    localparam int unsigned V_BACK   = 38;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned DEFAULT_FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

    typedef enum logic [1:0] {
        StWaitVs,
        StAlign,
        StStream
    } sink_state_e;

endpackage

// File: rtl/vga_pixel_stream_sink_if.sv
// Upstream pixel stream: valid/ready handshake carrying one pixel and a
// start-of-frame marker.
interface vga_pixel_stream_sink_if
    import vga_pkg::*;
#(
    parameter int unsigned DW = RGB_W
) ();

    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_sof;
    logic          s_ready;

    modport master (output s_valid, output s_data, output s_sof, input s_ready);
    modport slave (input s_valid, input s_data, input s_sof, output s_ready);

endinterface

// File: rtl/vga_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; flush empties it at the next edge and
// wins over a same-cycle push or pop.
module vga_sync_fifo
    import vga_pkg::*;
#(
    parameter int unsigned DW = RGB_W,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] level
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic          do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1] != rd_ptr_q[AW-1]) &&
                     (wr_ptr_q[AW-2:0] == rd_ptr_q[AW-2:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rdata   = mem[rd_ptr_q[AW-2:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q[AW-2:0]] <= wdata;
    end

endmodule

// File: rtl/vga_pixel_stream_sink.sv
// Buffers an upstream pixel stream and replays it on VGA pixel_enable with sync delayed
// to match; resyncs on vsync after underflow or SOF misalignment. Define
// VGA_FIFO_STATS_EN to expose FIFO occupancy and high-water mark.
module vga_pixel_stream_sink
    import vga_pkg::*;
#(
    parameter int unsigned DW = RGB_W,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
    parameter int unsigned CNT_BITS = 21,
    localparam int unsigned AW = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    Reset,
    vga_pixel_stream_sink_if.slave  up,
    input  logic                    vga_hs_i,
    input  logic                    vga_vs_i,
    input  logic                    pixel_enable,
    output logic                    vga_hs,
    output logic                    vga_vs,
    output logic [DW-1:0]           rgb,
    output logic                    underflow,
    output logic                    sof_err,
    input  logic                    clr_err
`ifdef VGA_FIFO_STATS_EN
    ,
    output logic [AW-1:0]           fifo_level,
    output logic [AW-1:0]           fifo_hwm
`endif
);

    sink_state_e         state_q;
    logic [CNT_BITS-1:0] wr_cnt_q;
    logic                accept, frame_end, sof_ok, vs_rise;
    logic                push, pop, flush, full, empty;
    logic                underflow_set, sof_err_set;
    logic [DW-1:0]       fifo_rdata;
    logic [AW-1:0]       level;

    // vga_vs is the registered vga_vs_i, so it doubles as the edge-detect history.
    assign vs_rise       = vga_vs_i && !vga_vs;
    assign up.s_ready    = (state_q == StAlign) || ((state_q == StStream) && !full);
    assign accept        = up.s_valid && up.s_ready;
    assign frame_end     = (wr_cnt_q == CNT_BITS'(FRAME_PIXELS));
    assign sof_ok        = (up.s_sof == frame_end);
    assign push          = accept && (((state_q == StAlign) && up.s_sof) ||
                                      ((state_q == StStream) && sof_ok));
    assign pop           = pixel_enable && (state_q == StStream) && !empty;
    assign flush         = (state_q == StWaitVs);
    assign underflow_set = pixel_enable && (state_q == StStream) && empty;
    assign sof_err_set   = accept && (state_q == StStream) && !sof_ok;

    vga_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .Reset (Reset),
        .push  (push),
        .wdata (up.s_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .flush (flush),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StWaitVs;
            wr_cnt_q  <= '0;
            vga_hs    <= 1'b0;
            vga_vs    <= 1'b0;
            rgb       <= '0;
            underflow <= 1'b0;
            sof_err   <= 1'b0;
        end else begin
            vga_hs    <= vga_hs_i;
            vga_vs    <= vga_vs_i;
            rgb       <= pop ? fifo_rdata : '0;
            underflow <= underflow_set || (underflow && !clr_err);
            sof_err   <= sof_err_set || (sof_err && !clr_err);
            unique case (state_q)
                StWaitVs: begin
                    wr_cnt_q <= '0;
                    if (vs_rise) state_q <= StAlign;
                end
                StAlign: begin
                    if (accept && up.s_sof) begin
                        wr_cnt_q <= CNT_BITS'(1);
                        state_q  <= StStream;
                    end
                end
                StStream: begin
                    if (accept && sof_ok) begin
                        wr_cnt_q <= frame_end ? CNT_BITS'(1) : wr_cnt_q + CNT_BITS'(1);
                    end
                    if (underflow_set || sof_err_set) state_q <= StWaitVs;
                end
                default: state_q <= StWaitVs;
            endcase
        end
    end

`ifdef VGA_FIFO_STATS_EN
    logic [AW-1:0] hwm_q;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            hwm_q <= '0;
        end else if (clr_err) begin
            hwm_q <= '0;
        end else if (level > hwm_q) begin
            hwm_q <= level;
        end
    end

    assign fifo_level = level;
    assign fifo_hwm   = hwm_q;
`else
    logic unused_level;
    assign unused_level = ^level;
`endif

endmodule

// File: tb/tb_vga_pixel_stream_sink.sv
// Bench for vga_pixel_stream_sink: directed scenarios plus a randomized phase, all
// checked every cycle against a queue-based model of the sink.
module tb_vga_pixel_stream_sink;

    localparam int DW = 12;
    localparam int DEPTH = 16;
    localparam int FP = 16;
    localparam int MW = 0;  // model modes: waiting for vsync, aligning, streaming
    localparam int MA = 1;
    localparam int MS = 2;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    logic vga_hs_i = 1'b0, vga_vs_i = 1'b0, pixel_enable = 1'b0, clr_err = 1'b0;
    logic vga_hs, vga_vs, underflow, sof_err;
    logic [DW-1:0] rgb;
`ifdef VGA_FIFO_STATS_EN
    logic [4:0] fifo_level, fifo_hwm;
`endif

    vga_pixel_stream_sink_if #(.DW(DW)) up_if ();

    vga_pixel_stream_sink #(
        .DW           (DW),
        .DEPTH        (DEPTH),
        .FRAME_PIXELS (FP),
        .CNT_BITS     (5)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .up           (up_if),
        .vga_hs_i     (vga_hs_i),
        .vga_vs_i     (vga_vs_i),
        .pixel_enable (pixel_enable),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .rgb          (rgb),
        .underflow    (underflow),
        .sof_err      (sof_err),
        .clr_err      (clr_err)
`ifdef VGA_FIFO_STATS_EN
        ,
        .fifo_level   (fifo_level),
        .fifo_hwm     (fifo_hwm)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: the FIFO is a queue, modes follow the sink's frame rules.
    int          m_st = MW;
    int          m_cnt = 0;
    int          e_hwm = 0;
    logic [DW-1:0] mq[$];
    logic        m_vs_prev = 1'b0, m_acc = 1'b0;
    logic [DW-1:0] e_rgb = '0;
    logic        e_hs = 1'b0, e_vs = 1'b0, e_uf = 1'b0, e_se = 1'b0;

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            mq.delete();
            m_st = MW; m_cnt = 0; m_vs_prev = 1'b0; m_acc = 1'b0; e_hwm = 0;
            e_rgb = '0; e_hs = 1'b0; e_vs = 1'b0; e_uf = 1'b0; e_se = 1'b0;
        end else begin
            logic rdy, uf_set, se_set;
            logic [DW-1:0] out;
            int nxt;
            e_hwm = clr_err ? 0 : ((mq.size() > e_hwm) ? mq.size() : e_hwm);
            rdy = (m_st == MA) || (m_st == MS && mq.size() < DEPTH);
            m_acc = up_if.s_valid && rdy;
            out = '0; uf_set = 1'b0; se_set = 1'b0; nxt = m_st;
            if (m_st == MS && pixel_enable) begin
                if (mq.size() == 0) begin uf_set = 1'b1; nxt = MW; end
                else out = mq.pop_front();
            end
            if (m_st == MW) begin
                mq.delete();
                if (vga_vs_i && !m_vs_prev) nxt = MA;
            end else if (m_st == MA) begin
                if (m_acc && up_if.s_sof) begin mq.push_back(up_if.s_data); m_cnt = 1; nxt = MS; end
            end else if (m_acc) begin
                if (up_if.s_sof == (m_cnt == FP)) begin
                    mq.push_back(up_if.s_data);
                    m_cnt = up_if.s_sof ? 1 : m_cnt + 1;
                end else begin
                    se_set = 1'b1; nxt = MW;
                end
            end
            m_st = nxt;
            e_rgb = out; e_hs = vga_hs_i; e_vs = vga_vs_i; m_vs_prev = vga_vs_i;
            e_uf = uf_set ? 1'b1 : (clr_err ? 1'b0 : e_uf);
            e_se = se_set ? 1'b1 : (clr_err ? 1'b0 : e_se);
        end
    end

    int n_tests = 0, n_fail = 0, src_rate = 100, acc_cnt = 0;
    logic [DW:0] src_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic exp_rdy;
        exp_rdy = (m_st == MA) || (m_st == MS && mq.size() < DEPTH);
        chk("rgb", rgb, e_rgb);
        chk("vga_hs", vga_hs, e_hs);
        chk("vga_vs", vga_vs, e_vs);
        chk("s_ready", up_if.s_ready, exp_rdy);
        chk("underflow", underflow, e_uf);
        chk("sof_err", sof_err, e_se);
`ifdef VGA_FIFO_STATS_EN
        chk("fifo_level", fifo_level, mq.size());
        chk("fifo_hwm", fifo_hwm, e_hwm);
`endif
    endtask

    // Check on the falling edge, then drive the source (holding any word not yet taken).
    task automatic step();
        logic [DW:0] w;
        @(negedge clk);
        compare();
        #1;
        if (!(up_if.s_valid && !m_acc)) begin
            if (src_q.size() > 0 && $urandom_range(99) < src_rate) begin
                w = src_q.pop_front();
                up_if.s_valid = 1'b1; up_if.s_sof = w[DW]; up_if.s_data = w[DW-1:0];
            end else begin
                up_if.s_valid = 1'b0; up_if.s_sof = 1'($urandom_range(1));
                up_if.s_data = DW'($urandom);
            end
        end
        if (up_if.s_valid && up_if.s_ready) acc_cnt++;
    endtask

    task automatic rst();
        Reset = 1'b1;
        src_q.delete();
        up_if.s_valid = 1'b0; up_if.s_sof = 1'b0; up_if.s_data = '0;
        pixel_enable = 1'b0; vga_vs_i = 1'b0; vga_hs_i = 1'b0; clr_err = 1'b0; src_rate = 100;
        step(); step();
        Reset = 1'b0;
    endtask

    task automatic vs_pulse();
        vga_vs_i = 1'b1; step(); step();
        vga_vs_i = 1'b0; step();
    endtask

    task automatic send(input int n, input logic [DW-1:0] base, input int sof_at);
        for (int i = 0; i < n; i++) src_q.push_back({(i == sof_at), base + DW'(i)});
    endtask

    initial begin
        up_if.s_valid = 1'b0; up_if.s_sof = 1'b0; up_if.s_data = '0;
        rst();
        chk("rst_rgb", rgb, 0);
        chk("rst_s_ready", up_if.s_ready, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_sof_err", sof_err, 0);
        chk("rst_vga_vs", vga_vs, 0);

        // Eight buffered pixels replayed one cycle after each enable.
        vs_pulse();
        send(8, 12'h001, 0);
        repeat (12) step();
        pixel_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin step(); chk("t1_rgb", rgb, i + 1); end
        pixel_enable = 1'b0; step();
        chk("t1_underflow", underflow, 0);

        // Non-SOF words in alignment are discarded.
        rst(); vs_pulse();
        src_q.push_back({1'b0, 12'h111}); src_q.push_back({1'b0, 12'h222});
        src_q.push_back({1'b0, 12'h333}); src_q.push_back({1'b1, 12'hABC});
        src_q.push_back({1'b0, 12'hABD});
        repeat (8) step();
        pixel_enable = 1'b1;
        step(); chk("t2_first", rgb, 12'hABC);
        step(); chk("t2_second", rgb, 12'hABD);
        pixel_enable = 1'b0;

        // Underflow on the fifth enable after four pixels.
        rst(); vs_pulse();
        send(4, 12'h001, 0);
        repeat (8) step();
        pixel_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin step(); chk("t3_rgb", rgb, i + 1); end
        step();
        chk("t3_underflow", underflow, 1);
        chk("t3_rgb_zero", rgb, 0);
        pixel_enable = 1'b0;
        src_q.push_back({1'b1, 12'h555});
        repeat (5) step();
        chk("t3_ready_low", up_if.s_ready, 0);
        vs_pulse();
        chk("t3_ready_after_vs", up_if.s_ready, 1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("t3_uf_cleared", underflow, 0);

        // SOF arriving at word 10 of a 16-pixel frame.
        rst(); vs_pulse();
        send(9, 12'h100, 0);
        src_q.push_back({1'b1, 12'h109});
        repeat (14) step();
        chk("t4_sof_err", sof_err, 1);
        chk("t4_ready_low", up_if.s_ready, 0);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("t4_sof_cleared", sof_err, 0);

        // Stalled display: FIFO fills to DEPTH, then drains in order across a frame edge.
        rst(); vs_pulse();
        acc_cnt = 0;
        send(16, 12'h200, 0); send(4, 12'h210, 0);
        repeat (30) step();
        chk("t5_accepts", acc_cnt, 16);
        chk("t5_ready_full", up_if.s_ready, 0);
        pixel_enable = 1'b1;
        step(); chk("t5_first", rgb, 12'h200);
        repeat (23) step();
        chk("t5_no_sof_err", sof_err, 0);
        chk("t5_underflow", underflow, 1);
        pixel_enable = 1'b0;

        // Asynchronous reset with words buffered.
        rst(); vs_pulse();
        vga_hs_i = 1'b1;
        send(6, 12'h301, 0);
        repeat (8) step();
        pixel_enable = 1'b1; step(); pixel_enable = 1'b0;
        chk("t6_pre_rgb", rgb, 12'h301);
        chk("t6_pre_hs", vga_hs, 1);
        #2;
        Reset = 1'b1; src_q.delete(); up_if.s_valid = 1'b0;
        #1;
        chk("t6_async_rgb", rgb, 0);
        chk("t6_async_hs", vga_hs, 0);
        chk("t6_async_ready", up_if.s_ready, 0);
        step(); step();
        Reset = 1'b0; vga_hs_i = 1'b0;
        send(4, 12'h3A0, 0);
        pixel_enable = 1'b1;
        repeat (10) step();
        chk("t6_no_output", rgb, 0);
        chk("t6_wait_vs", up_if.s_ready, 0);
        pixel_enable = 1'b0;
        vs_pulse();
        repeat (6) step();

        // Randomized frames with occasional length errors, stalls and clears.
        rst();
        begin
            int pe_rate;
            pe_rate = 50;
            for (int c = 0; c < 3000; c++) begin
                if (c % 300 == 0) begin
                    pe_rate = $urandom_range(90, 20);
                    src_rate = $urandom_range(100, 50);
                end
                vga_vs_i = (c % 300 >= 5) && (c % 300 < 8);
                vga_hs_i = (c % 40 < 4);
                pixel_enable = ($urandom_range(99) < pe_rate);
                clr_err = ($urandom_range(199) == 0);
                if (src_q.size() < 4) begin
                    int r, len;
                    r = $urandom_range(9);
                    len = (r == 0) ? FP - 1 : ((r == 1) ? FP + 1 : FP);
                    for (int i = 0; i < len; i++) src_q.push_back({(i == 0), DW'($urandom)});
                end
                step();
            end
        end
        pixel_enable = 1'b0; clr_err = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pixel_stream_sink.md
Name: vga_pixel_stream_sink

Overview:
Consumes a 12-bit RGB pixel stream (valid/ready, start-of-frame marked) from the upstream pixel source and buffers it in a small FIFO. It pops one pixel per active-display cycle, driven by the sync and pixel_enable outputs of the VGA timing generator. It emits RGB plus 1-cycle-delayed HS/VS so colour and sync stay aligned at the DAC. It detects underflow and frame misalignment, then resynchronises at the next vertical sync.

Parameters:
DW, 12, pixel width (4:4:4 RGB)
DEPTH, 16, FIFO depth in words; power of two, >= 4
FRAME_PIXELS, 1310720, active pixels per frame (1280x1024)
CNT_BITS, 21, width of frame word counter; must satisfy 2**CNT_BITS > FRAME_PIXELS

Ports:
clk  in  1  pixel clock
Reset  in  1  asynchronous, active-high reset
s_valid  in  1  upstream pixel valid
s_data  in  DW  upstream pixel
s_sof  in  1  marks first pixel of a frame; qualified by s_valid
s_ready  out  1  sink accepts s_data this cycle
vga_hs_i  in  1  hsync from timing generator (active-high retrace)
vga_vs_i  in  1  vsync from timing generator (active-high retrace)
pixel_enable  in  1  active-display strobe from timing generator
vga_hs  out  1  vga_hs_i delayed 1 cycle
vga_vs  out  1  vga_vs_i delayed 1 cycle
rgb  out  DW  pixel to DAC
underflow  out  1  sticky; pixel_enable seen with FIFO empty in STREAM
sof_err  out  1  sticky; s_sof position mismatch
clr_err  in  1  synchronous clear of the sticky flags

Behaviour:
- Reset values: s_ready=0, vga_hs=0, vga_vs=0, rgb=0, underflow=0, sof_err=0; FIFO empty; state=WAIT_VS; wr_cnt=0.
- Handshake: a word is accepted when s_valid && s_ready. s_data/s_sof must stay stable while s_valid && !s_ready.
- vs_rise = vga_vs_i && !vs_q, where vs_q is the registered vga_vs_i.
- FSM:
  - WAIT_VS: s_ready=0; FIFO flushed every cycle; on vs_rise go to ALIGN.
  - ALIGN: s_ready=1. Accepted words without s_sof are discarded. An accepted word with s_sof is written to the FIFO, wr_cnt=1, go to STREAM.
  - STREAM: s_ready=!full. Each accepted word is written and wr_cnt increments.
    - wr_cnt==FRAME_PIXELS with the accepted word having s_sof: wr_cnt=1, stay in STREAM (normal frame boundary).
    - Accepted word with s_sof while wr_cnt!=FRAME_PIXELS, or without s_sof while wr_cnt==FRAME_PIXELS: set sof_err, go to WAIT_VS (word dropped).
    - pixel_enable && FIFO empty: set underflow, go to WAIT_VS.
- Pop: pop when pixel_enable && state==STREAM && !empty. rgb <= popped data at the next edge; otherwise rgb <= 0. Latency: pixel_enable at cycle n gives rgb at n+1, aligned with vga_hs/vga_vs.
- Simultaneous push and pop in the same cycle are both performed, and the level is unchanged. When full, s_ready=0. A pop in that same cycle does not raise s_ready combinationally; the registered-full style is acceptable.
- Transition to WAIT_VS: the flush takes effect the next cycle, and rgb=0 from that point.
- clr_err has priority below a same-cycle set: if set and clear coincide, the flag stays 1.
- Reset asserted mid-frame: everything returns to reset values immediately (async). After Reset deasserts, the block waits for the next vs_rise.
- Pointers are AW=$clog2(DEPTH)+1 bits; wrap is natural modulo. full/empty are derived from MSB compare.

Optional Feature:
VGA_FIFO_STATS_EN
- With the macro: adds outputs fifo_level (AW bits, current occupancy) and fifo_hwm (AW bits). fifo_hwm is the high-water mark, updated each cycle to max(hwm, level) and cleared by clr_err.
- Without the macro: the outputs and registers do not exist; behaviour is otherwise identical.

Decomposition:
- vga_pkg holds:
  - the state enum (WAIT_VS, ALIGN, STREAM)
  - RGB_W=12
  - default FRAME_PIXELS, and the H/V timing constants shared with the timing generator
- One sub-module: vga_sync_fifo (DW, DEPTH; push/pop/flush/full/empty/level).

Test Plan:
- Reset, vs_rise, then stream 8 pixels starting with sof (0x001..0x008) ahead of pixel_enable -> rgb shows 0x001..0x008 one cycle after each pixel_enable; underflow=0.
- In ALIGN, send 3 non-sof words then a sof word 0xABC -> first three discarded with s_ready=1; first displayed pixel is 0xABC.
- Hold s_valid=0 after 4 pixels while pixel_enable stays high -> underflow=1 on the 5th enable; rgb=0; s_ready=0 until the next vs_rise.
- FRAME_PIXELS=16: send sof at word 10 -> sof_err=1, state WAIT_VS. After clr_err, sof_err=0.
- Stall pixel_enable with s_valid held high -> s_ready drops after DEPTH=16 accepts; no data lost; order preserved on resume.
- Assert Reset mid-STREAM with 5 words buffered -> all outputs 0 asynchronously. After release, no pixel is output before the next vs_rise plus sof.
